// File: rtl/func_decoder_sweep_ctrl_if.sv
// Signal bundle between the lab control / decoder stub (master) and the
// sweep controller (slave).
interface func_decoder_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic [23:0] expected;
  logic [2:0]  dec_f;
  logic [2:0]  dec_i;
  logic        busy;
  logic        done;
  logic        pass;
  logic [23:0] table_out;
  logic [3:0]  mismatch_cnt;
  logic [2:0]  first_bad;

  modport master (
    output start, abort, expected, dec_f,
    input  dec_i, busy, done, pass, table_out, mismatch_cnt, first_bad
  );

  modport slave (
    input  start, abort, expected, dec_f,
    output dec_i, busy, done, pass, table_out, mismatch_cnt, first_bad
  );
endinterface

// File: rtl/func_decoder_sweep_ctrl.sv
// Steps the decoder select through minterms 0..7, samples F[3:1] after a
// programmable dwell, and grades the captured truth table against a latched one.
//
//   state | meaning
//   IDLE  | waiting for start; results of the last sweep held
//   RUN   | sweeping minterms, busy high
//   DONE  | one-cycle done pulse, pass valid
module func_decoder_sweep_ctrl #(
  parameter int unsigned DWELL = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  func_decoder_sweep_ctrl_if.slave sw_if
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0] DWELL_M1 = 4'(DWELL - 1);

  state_t      state_q, state_d;
  logic [2:0]  dec_q, dec_d;
  logic [3:0]  dwell_q, dwell_d;
  logic [23:0] exp_q, exp_d;
  logic [23:0] table_q, table_d;
  logic [3:0]  mcnt_q, mcnt_d;
  logic [2:0]  first_q, first_d;
  logic        pass_q, pass_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [4:0]  fld_lo;
  logic        mism;

  assign fld_lo = 5'(dec_q) * 5'd3;
  assign mism   = (sw_if.dec_f != exp_q[fld_lo +: 3]);

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    dwell_d = dwell_q;
    exp_d   = exp_q;
    table_d = table_q;
    mcnt_d  = mcnt_q;
    first_d = first_q;
    pass_d  = pass_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sw_if.start) begin
          state_d = S_RUN;
          exp_d   = sw_if.expected;
          dec_d   = 3'd0;
          dwell_d = 4'd0;
          table_d = 24'd0;
          mcnt_d  = 4'd0;
          first_d = 3'd0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        // abort wins over a sample falling on the same edge
        if (sw_if.abort) begin
          state_d = S_IDLE;
          dec_d   = 3'd0;
          dwell_d = 4'd0;
          pass_d  = 1'b0;
        end else if (dwell_q == DWELL_M1) begin
          table_d[fld_lo +: 3] = sw_if.dec_f;
          if (mism) begin
            mcnt_d = mcnt_q + 4'd1;
            if (mcnt_q == 4'd0) first_d = dec_q;
          end
          dwell_d = 4'd0;
          if (dec_q == 3'd7) begin
            state_d = S_DONE;
            dec_d   = 3'd0;
            pass_d  = (mcnt_d == 4'd0);
          end else begin
            dec_d = dec_q + 3'd1;
          end
        end else begin
          dwell_d = dwell_q + 4'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dec_q   <= 3'd0;
      dwell_q <= 4'd0;
      exp_q   <= 24'd0;
      table_q <= 24'd0;
      mcnt_q  <= 4'd0;
      first_q <= 3'd0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      dwell_q <= dwell_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      mcnt_q  <= mcnt_d;
      first_q <= first_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sw_if.dec_i        = dec_q;
  assign sw_if.busy         = busy_q;
  assign sw_if.done         = done_q;
  assign sw_if.pass         = pass_q;
  assign sw_if.table_out    = table_q;
  assign sw_if.mismatch_cnt = mcnt_q;
  assign sw_if.first_bad    = first_q;

endmodule

// File: tb/tb_func_decoder_sweep_ctrl.sv
// Bench for the decoder sweep controller: two instances (dwell 2 and dwell 1)
// driven by a table-driven decoder stub, graded by a queued reference model.
module tb_func_decoder_sweep_ctrl;

  typedef struct packed {
    logic [23:0] tbl;
    logic [3:0]  mc;
    logic [2:0]  fb;
    logic        ps;
  } res_t;

  logic clk;
  logic rst_n;
  logic [23:0] lut_a, lut_b;
  int checks, errors;
  res_t qa[$];
  res_t qb[$];

  func_decoder_sweep_ctrl_if ifa();
  func_decoder_sweep_ctrl_if ifb();

  func_decoder_sweep_ctrl #(.DWELL(2)) dut_a (.clk(clk), .rst_n(rst_n), .sw_if(ifa));
  func_decoder_sweep_ctrl #(.DWELL(1)) dut_b (.clk(clk), .rst_n(rst_n), .sw_if(ifb));

  // decoder stub: F[3:1] for minterm k is field k of the lookup table
  assign ifa.dec_f = lut_a[int'(ifa.dec_i) * 3 +: 3];
  assign ifb.dec_f = lut_b[int'(ifb.dec_i) * 3 +: 3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [23:0] lut, input logic [23:0] ex);
    res_t r;
    logic [2:0] got;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      got = lut[3*k +: 3];
      r.tbl[3*k +: 3] = got;
      if (got != ex[3*k +: 3]) begin
        if (r.mc == 4'd0) r.fb = 3'(k);
        r.mc = r.mc + 4'd1;
      end
    end
    r.ps = (r.mc == 4'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic start_a(input logic [23:0] lut, input logic [23:0] ex,
                         input bit push, input bit with_abort);
    @(negedge clk);
    lut_a = lut;
    ifa.expected = ex;
    ifa.start = 1'b1;
    ifa.abort = with_abort;
    if (push) qa.push_back(model(lut, ex));
    @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b0;
    ifa.abort = 1'b0;
  endtask

  task automatic wait_done_a(input int maxc);
    int n;
    n = 0;
    while (!ifa.done && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("a_done_seen", 32'(ifa.done), 32'd1);
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_dec_i"}, 32'(ifa.dec_i), 32'd0);
    chk({tag, "_busy"},  32'(ifa.busy), 32'd0);
    chk({tag, "_done"},  32'(ifa.done), 32'd0);
    chk({tag, "_pass"},  32'(ifa.pass), 32'd0);
    chk({tag, "_table"}, 32'(ifa.table_out), 32'd0);
    chk({tag, "_mcnt"},  32'(ifa.mismatch_cnt), 32'd0);
    chk({tag, "_first"}, 32'(ifa.first_bad), 32'd0);
  endtask

  // monitor: every done pulse is graded against the oldest pending sweep
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ifa.done) begin
        chk("a_done_pending", 32'(qa.size() > 0), 32'd1);
        if (qa.size() > 0) begin
          e = qa.pop_front();
          chk("a_table", 32'(ifa.table_out), 32'(e.tbl));
          chk("a_mcnt",  32'(ifa.mismatch_cnt), 32'(e.mc));
          chk("a_first", 32'(ifa.first_bad), 32'(e.fb));
          chk("a_pass",  32'(ifa.pass), 32'(e.ps));
        end
      end
      if (rst_n && ifb.done) begin
        chk("b_done_pending", 32'(qb.size() > 0), 32'd1);
        if (qb.size() > 0) begin
          e = qb.pop_front();
          chk("b_table", 32'(ifb.table_out), 32'(e.tbl));
          chk("b_mcnt",  32'(ifb.mismatch_cnt), 32'(e.mc));
          chk("b_first", 32'(ifb.first_bad), 32'(e.fb));
          chk("b_pass",  32'(ifb.pass), 32'(e.ps));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] lut, ex;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    lut_a = 24'd0;
    lut_b = 24'd0;
    ifa.start = 1'b0; ifa.abort = 1'b0; ifa.expected = 24'd0;
    ifb.start = 1'b0; ifb.abort = 1'b0; ifb.expected = 24'd0;
    repeat (3) @(negedge clk);
    chk_a_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // identity stub, matching table: check dec_i stepping and done timing
    start_a(24'hFAC688, 24'hFAC688, 1'b1, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      chk("t1_dec_i", 32'(ifa.dec_i), 32'((c - 1) / 2));
      chk("t1_busy",  32'(ifa.busy), 32'd1);
      chk("t1_done",  32'(ifa.done), 32'd0);
      @(negedge clk);
    end
    chk("t1_done_c17", 32'(ifa.done), 32'd1);
    chk("t1_busy_c17", 32'(ifa.busy), 32'd0);
    @(negedge clk);
    chk("t1_done_c18", 32'(ifa.done), 32'd0);

    // single mismatch at minterm 5, then all-zero decoder
    start_a(24'hFAC688, 24'hFA4688, 1'b1, 1'b0);
    wait_done_a(100);
    start_a(24'h000000, 24'hFAC688, 1'b1, 1'b0);
    wait_done_a(100);

    // abort in cycle 5: partial table holds minterms 0..1
    start_a(24'hFAC688, 24'hFAC688, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    ifa.abort = 1'b1;
    @(negedge clk);
    ifa.abort = 1'b0;
    chk("t4_busy",  32'(ifa.busy), 32'd0);
    chk("t4_dec_i", 32'(ifa.dec_i), 32'd0);
    chk("t4_done",  32'(ifa.done), 32'd0);
    chk("t4_pass",  32'(ifa.pass), 32'd0);
    chk("t4_table", 32'(ifa.table_out), 32'h000008);
    chk("t4_mcnt",  32'(ifa.mismatch_cnt), 32'd0);
    repeat (20) @(negedge clk);

    // reset in cycle 9 of a sweep, then a clean sweep
    start_a(24'hFAC688, 24'h0AC688, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_a_zero("t5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    start_a(24'hFAC688, 24'h0AC688, 1'b1, 1'b0);
    wait_done_a(100);

    // random tables; first run also asserts abort alongside start
    for (int i = 0; i < 20; i++) begin
      lut = 24'($urandom);
      ex  = (i % 4 == 0) ? lut : (lut ^ 24'($urandom & $urandom & $urandom));
      start_a(lut, ex, 1'b1, i == 0);
      wait_done_a(100);
    end

    // dwell 1 with start held: sweeps latch expected at edges 0,10,20,30
    @(negedge clk);
    lut_b = 24'hFAC688;
    ifb.expected = 24'hFAC688;
    ifb.start = 1'b1;
    for (int e = 0; e < 40; e++) begin
      if (e % 10 == 0) qb.push_back(model(lut_b, ifb.expected));
      if (e == 4 || e == 24) ifb.expected = 24'($urandom);
      if (e == 39) ifb.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("t6_done_cycle", 32'(ifb.done), 32'(((e + 1) % 10) == 9));
    end
    ifb.start = 1'b0;

    repeat (5) @(negedge clk);
    chk("a_queue_empty", 32'(qa.size()), 32'd0);
    chk("b_queue_empty", 32'(qb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
